// File: rtl/axi4_sram_responder.sv
// axi4_sram_responder: AXI4 burst slave in front of an R0/W0 SRAM macro pair.
// Serves one transaction at a time; partial-strobe writes become read-modify-write.
module axi4_sram_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    SRAM_AW    = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    ID_WIDTH   = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  s_aw_valid,
  output logic                  s_aw_ready,
  input  logic [ID_WIDTH-1:0]   s_aw_id,
  input  logic [ADDR_WIDTH-1:0] s_aw_addr,
  input  logic [7:0]            s_aw_len,
  input  logic [2:0]            s_aw_size,
  input  logic [1:0]            s_aw_burst,
  input  logic                  s_w_valid,
  output logic                  s_w_ready,
  input  logic [31:0]           s_w_data,
  input  logic [3:0]            s_w_strb,
  input  logic                  s_w_last,
  output logic                  s_b_valid,
  input  logic                  s_b_ready,
  output logic [ID_WIDTH-1:0]   s_b_id,
  output logic [1:0]            s_b_resp,
  input  logic                  s_ar_valid,
  output logic                  s_ar_ready,
  input  logic [ID_WIDTH-1:0]   s_ar_id,
  input  logic [ADDR_WIDTH-1:0] s_ar_addr,
  input  logic [7:0]            s_ar_len,
  input  logic [2:0]            s_ar_size,
  input  logic [1:0]            s_ar_burst,
  output logic                  s_r_valid,
  input  logic                  s_r_ready,
  output logic [ID_WIDTH-1:0]   s_r_id,
  output logic [31:0]           s_r_data,
  output logic [1:0]            s_r_resp,
  output logic                  s_r_last,
  output logic                  R0_clk,
  output logic                  R0_en,
  output logic [SRAM_AW-1:0]    R0_addr,
  input  logic [31:0]           R0_data,
  output logic                  W0_clk,
  output logic                  W0_en,
  output logic [SRAM_AW-1:0]    W0_addr,
  output logic [31:0]           W0_data
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, RMW_RD, RMW_WR, WR_RESP} state_t;

  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;
  localparam logic [1:0]            RESP_DECERR = 2'b11;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP   = 4;

  // Oversized/reserved bursts and WRAP lengths that are not 2/4/8/16 beats are rejected.
  function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
    logic wrap_ok;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size != 3'd2) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok);
  endfunction

  logic [1:0]            rst_pipe;
  logic                  rst_n;
  state_t                state, state_nxt;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_incr, addr_next, wrap_mask;
  logic [7:0]            len_q, beat_q;
  logic [1:0]            burst_q, worst_q, beat_resp, w_resp;
  logic                  bad_q, last_write_q, rd_first_q, w0_en_q;
  logic [31:0]           wdata_q, rdata_q, w0_data_q, merged, rd_word;
  logic [3:0]            wstrb_q;
  logic [SRAM_AW-1:0]    w0_addr_q, word;
  logic                  in_range, is_last, aw_fire, ar_fire, w_fire;
  logic                  w_full, w_partial, rd_stall;

  assign in_range  = addr_q[ADDR_WIDTH-1:SRAM_AW+2] == BASE_ADDR[ADDR_WIDTH-1:SRAM_AW+2];
  assign word      = addr_q[SRAM_AW+1:2];
  assign beat_resp = bad_q ? RESP_SLVERR : (in_range ? RESP_OKAY : RESP_DECERR);
  assign is_last   = beat_q == len_q;
  assign addr_incr = addr_q + ADDR_STEP;
  assign wrap_mask = {{(ADDR_WIDTH-10){1'b0}}, len_q, 2'b11};
  assign addr_next = (burst_q == 2'b00) ? addr_q :
                     (burst_q == 2'b10) ? ((addr_q & ~wrap_mask) | (addr_incr & wrap_mask)) :
                     addr_incr;

  // Round robin: whoever was not served last wins a tie; a lone request always proceeds.
  assign s_aw_ready = rst_n && (state == IDLE) && (!last_write_q || !s_ar_valid);
  assign s_ar_ready = rst_n && (state == IDLE) && (last_write_q || !s_aw_valid);
  assign s_w_ready  = state == WR_DATA;
  assign s_b_valid  = state == WR_RESP;
  assign s_r_valid  = state == RD_DATA;

  assign aw_fire   = s_aw_valid && s_aw_ready;
  assign ar_fire   = s_ar_valid && s_ar_ready;
  assign w_fire    = s_w_valid && s_w_ready;
  assign w_full    = (beat_resp == RESP_OKAY) && (s_w_strb == 4'hF);
  assign w_partial = (beat_resp == RESP_OKAY) && (s_w_strb != 4'h0) && (s_w_strb != 4'hF);
  assign w_resp    = ((s_w_last != is_last) && (beat_resp == RESP_OKAY)) ? RESP_SLVERR : beat_resp;
  // A write still landing this cycle holds off any read so both ports never collide.
  assign rd_stall  = w0_en_q && (beat_resp == RESP_OKAY);

  assign rd_word  = (beat_resp == RESP_OKAY) ? R0_data : 32'h0;
  assign s_r_data = rd_first_q ? rd_word : rdata_q;
  assign s_r_id   = id_q;
  assign s_r_resp = (state == RD_DATA) ? beat_resp : RESP_OKAY;
  assign s_r_last = (state == RD_DATA) && is_last;
  assign s_b_id   = id_q;
  assign s_b_resp = (state == WR_RESP) ? worst_q : RESP_OKAY;

  assign R0_clk  = clock;
  assign W0_clk  = clock;
  assign R0_addr = word;
  assign R0_en   = ((state == RD_REQ) && (beat_resp == RESP_OKAY) && !w0_en_q) ||
                   ((state == RMW_RD) && !w0_en_q);
  assign W0_en   = w0_en_q;
  assign W0_addr = w0_addr_q;
  assign W0_data = w0_data_q;

  // Merge the strobed bytes of the held beat over the word just read back.
  always_comb begin
    merged = R0_data;
    for (int i = 0; i < 4; i++) begin
      if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // Reset asserts immediately but is released on a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (aw_fire) state_nxt = WR_DATA;
               else if (ar_fire) state_nxt = RD_REQ;
      RD_REQ:  if (!rd_stall) state_nxt = RD_DATA;
      RD_DATA: if (s_r_ready) state_nxt = is_last ? IDLE : RD_REQ;
      WR_DATA: if (w_fire) begin
                 if (w_partial)    state_nxt = RMW_RD;
                 else if (is_last) state_nxt = WR_RESP;
               end
      RMW_RD:  if (!w0_en_q) state_nxt = RMW_WR;
      RMW_WR:  state_nxt = is_last ? WR_RESP : WR_DATA;
      WR_RESP: if (s_b_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction context, beat sequencing, read capture and registered SRAM writes.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      id_q <= '0; addr_q <= '0; len_q <= '0; beat_q <= '0; burst_q <= '0;
      bad_q <= 1'b0; worst_q <= RESP_OKAY; last_write_q <= 1'b0; rd_first_q <= 1'b0;
      rdata_q <= '0; wdata_q <= '0; wstrb_q <= '0;
      w0_en_q <= 1'b0; w0_addr_q <= '0; w0_data_q <= '0;
    end else begin
      w0_en_q <= 1'b0;
      case (state)
        IDLE: begin
          if (aw_fire) begin
            id_q <= s_aw_id; addr_q <= s_aw_addr; len_q <= s_aw_len; burst_q <= s_aw_burst;
            bad_q <= burst_bad(s_aw_size, s_aw_burst, s_aw_len);
            beat_q <= '0; worst_q <= RESP_OKAY; last_write_q <= 1'b1;
          end else if (ar_fire) begin
            id_q <= s_ar_id; addr_q <= s_ar_addr; len_q <= s_ar_len; burst_q <= s_ar_burst;
            bad_q <= burst_bad(s_ar_size, s_ar_burst, s_ar_len);
            beat_q <= '0; worst_q <= RESP_OKAY; last_write_q <= 1'b0;
          end
        end
        RD_REQ: if (!rd_stall) rd_first_q <= 1'b1;
        RD_DATA: begin
          rd_first_q <= 1'b0;
          if (rd_first_q) rdata_q <= rd_word;
          if (s_r_ready) begin
            addr_q <= addr_next;
            beat_q <= beat_q + 8'd1;
          end
        end
        WR_DATA: begin
          if (w_fire) begin
            worst_q <= (w_resp > worst_q) ? w_resp : worst_q;
            wdata_q <= s_w_data;
            wstrb_q <= s_w_strb;
            if (w_full) begin
              w0_en_q   <= 1'b1;
              w0_addr_q <= word;
              w0_data_q <= s_w_data;
            end
            if (!w_partial) begin
              addr_q <= addr_next;
              beat_q <= beat_q + 8'd1;
            end
          end
        end
        RMW_WR: begin
          w0_en_q   <= 1'b1;
          w0_addr_q <= word;
          w0_data_q <= merged;
          addr_q    <= addr_next;
          beat_q    <= beat_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_sram_responder.sv
// tb_axi4_sram_responder: directed test of the AXI4-to-SRAM responder with a
// behavioural R0/W0 SRAM model and bench-side port activity counters.
module tb_axi4_sram_responder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_aw_valid = 1'b0, s_aw_id = 1'b0;
  logic [31:0] s_aw_addr = '0;
  logic [7:0]  s_aw_len = '0;
  logic [2:0]  s_aw_size = 3'd2;
  logic [1:0]  s_aw_burst = 2'b01;
  logic        s_w_valid = 1'b0, s_w_last = 1'b0;
  logic [31:0] s_w_data = '0;
  logic [3:0]  s_w_strb = '0;
  logic        s_b_ready = 1'b0;
  logic        s_ar_valid = 1'b0, s_ar_id = 1'b0;
  logic [31:0] s_ar_addr = '0;
  logic [7:0]  s_ar_len = '0;
  logic [2:0]  s_ar_size = 3'd2;
  logic [1:0]  s_ar_burst = 2'b01;
  logic        s_r_ready = 1'b0;
  logic [31:0] R0_data = '0;

  logic        s_aw_ready, s_w_ready, s_b_valid, s_b_id, s_ar_ready;
  logic        s_r_valid, s_r_id, s_r_last;
  logic [1:0]  s_b_resp, s_r_resp;
  logic [31:0] s_r_data, W0_data;
  logic        R0_clk, R0_en, W0_clk, W0_en;
  logic [7:0]  R0_addr, W0_addr;

  int checks = 0;
  int failures = 0;

  axi4_sram_responder #(.ADDR_WIDTH(32), .SRAM_AW(8), .BASE_ADDR(32'h0), .ID_WIDTH(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr),
    .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_w_last(s_w_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_data(s_r_data),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .R0_clk(R0_clk), .R0_en(R0_en), .R0_addr(R0_addr), .R0_data(R0_data),
    .W0_clk(W0_clk), .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data)
  );

  always #5 clock = ~clock;

  // SRAM model plus counters of port activity and same-address collisions.
  logic [31:0] mem [256];
  int          cyc = 0, r0_cnt = 0, w0_cnt = 0, r0_cyc = 0, w0_cyc = 0, hazard_cnt = 0;
  logic [7:0]  w0_last_addr = '0;
  logic [31:0] w0_last_data = '0;

  always @(posedge clock) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[5]   <= 32'h11223344;
      mem[6]   <= 32'h66666666;
      mem[7]   <= 32'h77777777;
      mem[100] <= 32'hCAFEF00D;
      mem[255] <= 32'hA5A500FF;
    end else begin
      if (R0_en) begin
        r0_cnt++;
        r0_cyc = cyc;
        R0_data <= mem[R0_addr];
      end
      if (W0_en) begin
        w0_cnt++;
        w0_cyc = cyc;
        w0_last_addr = W0_addr;
        w0_last_data = W0_data;
        mem[W0_addr] <= W0_data;
      end
      if (R0_en && W0_en && (R0_addr == W0_addr)) hazard_cnt++;
    end
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic aw_wait();
    int n = 0;
    #1;
    while (!s_aw_ready && n < 50) begin @(posedge clock); #1; n++; end
    if (!s_aw_ready) begin
      checks++; failures++;
      $display("[TB] FAIL aw_handshake: aw_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge clock); #1;
    s_aw_valid = 1'b0;
  endtask

  task automatic aw_send(input logic id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    s_aw_id = id; s_aw_addr = addr; s_aw_len = len; s_aw_size = size; s_aw_burst = burst;
    s_aw_valid = 1'b1;
    aw_wait();
  endtask

  task automatic ar_wait();
    int n = 0;
    #1;
    while (!s_ar_ready && n < 50) begin @(posedge clock); #1; n++; end
    if (!s_ar_ready) begin
      checks++; failures++;
      $display("[TB] FAIL ar_handshake: ar_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge clock); #1;
    s_ar_valid = 1'b0;
  endtask

  task automatic ar_send(input logic id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    s_ar_id = id; s_ar_addr = addr; s_ar_len = len; s_ar_size = size; s_ar_burst = burst;
    s_ar_valid = 1'b1;
    ar_wait();
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    s_w_data = data; s_w_strb = strb; s_w_last = last; s_w_valid = 1'b1;
    #1;
    while (!s_w_ready && n < 50) begin @(posedge clock); #1; n++; end
    if (!s_w_ready) begin
      checks++; failures++;
      $display("[TB] FAIL w_handshake: w_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge clock); #1;
    s_w_valid = 1'b0; s_w_last = 1'b0;
  endtask

  task automatic b_get(output logic [1:0] resp, output logic id);
    int n = 0;
    s_b_ready = 1'b1;
    #1;
    while (!s_b_valid && n < 50) begin @(posedge clock); #1; n++; end
    if (!s_b_valid) begin
      checks++; failures++;
      $display("[TB] FAIL b_handshake: b_valid=0 after %0d cycles, required 1", n);
    end
    resp = s_b_resp; id = s_b_id;
    @(posedge clock); #1;
    s_b_ready = 1'b0;
  endtask

  task automatic r_get(output logic [31:0] data, output logic [1:0] resp, output logic last);
    int n = 0;
    s_r_ready = 1'b1;
    #1;
    while (!s_r_valid && n < 50) begin @(posedge clock); #1; n++; end
    if (!s_r_valid) begin
      checks++; failures++;
      $display("[TB] FAIL r_handshake: r_valid=0 after %0d cycles, required 1", n);
    end
    data = s_r_data; resp = s_r_resp; last = s_r_last;
    @(posedge clock); #1;
    s_r_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] outs;
    repeat (3) @(posedge clock);
    #1;
    outs = {s_aw_ready, s_ar_ready, s_w_ready, s_b_valid, s_r_valid, R0_en, W0_en,
            s_r_last, |s_r_resp, |s_b_resp, |s_r_data};
    checks++;
    if (outs !== 11'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %b, required all zero", outs);
    end
    reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (s_aw_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL idle_aw_ready: got %b, required 1", s_aw_ready);
    end
  endtask

  task automatic test_single_write();
    logic [1:0] resp; logic id, last; logic [31:0] data; int w0_base;
    w0_base = w0_cnt;
    aw_send(1'b1, 32'h10, 8'd0, 3'd2, 2'b01);
    w_send(32'hDEADBEEF, 4'hF, 1'b1);
    b_get(resp, id);
    checks++;
    if (resp !== 2'b00 || id !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_bresp: got resp=%0d id=%0d, required resp=0 id=1", resp, id);
    end
    checks++;
    if (w0_cnt - w0_base !== 1 || w0_last_addr !== 8'd4 || w0_last_data !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL single_w0: got pulses=%0d addr=%0d data=%h, required 1/4/deadbeef",
               w0_cnt - w0_base, w0_last_addr, w0_last_data);
    end
    ar_send(1'b0, 32'h10, 8'd0, 3'd2, 2'b01);
    checks++;
    if (s_r_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rd_latency_early: rvalid got %b one cycle after ar, required 0", s_r_valid);
    end
    @(posedge clock); #1;
    checks++;
    if (s_r_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rd_latency: rvalid got %b two cycles after ar, required 1", s_r_valid);
    end
    r_get(data, resp, last);
    checks++;
    if (data !== 32'hDEADBEEF || resp !== 2'b00 || last !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_read: got %h resp=%0d last=%b, required deadbeef 0 1",
               data, resp, last);
    end
  endtask

  task automatic test_incr_burst();
    logic [1:0] resp; logic id, last, stable; logic [31:0] data; int n;
    aw_send(1'b0, 32'h0, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) w_send(32'(i + 1), 4'hF, i == 3);
    b_get(resp, id);
    checks++;
    if (resp !== 2'b00) begin
      failures++;
      $display("[TB] FAIL incr_bresp: got %0d, required 0", resp);
    end
    ar_send(1'b0, 32'h0, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        n = 0;
        while (!s_r_valid && n < 20) begin @(posedge clock); #1; n++; end
        stable = 1'b1;
        for (int k = 0; k < 3; k++) begin
          if (s_r_valid !== 1'b1 || s_r_data !== 32'd2) stable = 1'b0;
          @(posedge clock); #1;
        end
        checks++;
        if (stable !== 1'b1 || s_r_data !== 32'd2) begin
          failures++;
          $display("[TB] FAIL incr_hold: got data=%h valid=%b while stalled, required 2 1",
                   s_r_data, s_r_valid);
        end
      end
      r_get(data, resp, last);
      checks++;
      if (data !== 32'(i + 1) || resp !== 2'b00 || last !== (i == 3)) begin
        failures++;
        $display("[TB] FAIL incr_beat%0d: got %h resp=%0d last=%b, required %h 0 %b",
                 i, data, resp, last, i + 1, i == 3);
      end
    end
  endtask

  task automatic test_rmw();
    logic [1:0] resp; logic id, last; logic [31:0] data; int r0_base, w0_base;
    r0_base = r0_cnt; w0_base = w0_cnt;
    aw_send(1'b0, 32'h14, 8'd0, 3'd2, 2'b01);
    w_send(32'hAABBCCDD, 4'b0101, 1'b1);
    b_get(resp, id);
    checks++;
    if (resp !== 2'b00 || r0_cnt - r0_base !== 1 || w0_cnt - w0_base !== 1 || !(r0_cyc < w0_cyc)) begin
      failures++;
      $display("[TB] FAIL rmw_sequence: got resp=%0d reads=%0d writes=%0d order=%0d/%0d, required 0 1 1 read-first",
               resp, r0_cnt - r0_base, w0_cnt - w0_base, r0_cyc, w0_cyc);
    end
    checks++;
    if (w0_last_data !== 32'h11BB33DD || w0_last_addr !== 8'd5) begin
      failures++;
      $display("[TB] FAIL rmw_merge: got %h at %0d, required 11bb33dd at 5", w0_last_data, w0_last_addr);
    end
    ar_send(1'b0, 32'h14, 8'd0, 3'd2, 2'b01);
    r_get(data, resp, last);
    checks++;
    if (data !== 32'h11BB33DD) begin
      failures++;
      $display("[TB] FAIL rmw_readback: got %h, required 11bb33dd", data);
    end
  endtask

  task automatic test_wrap_and_edge();
    logic [1:0] resp; logic last; logic [31:0] data; int r0_base;
    logic [31:0] exp_wrap [4] = '{32'h66666666, 32'h77777777, 32'hDEADBEEF, 32'h11BB33DD};
    ar_send(1'b0, 32'h18, 8'd3, 3'd2, 2'b10);
    for (int i = 0; i < 4; i++) begin
      r_get(data, resp, last);
      checks++;
      if (data !== exp_wrap[i] || resp !== 2'b00 || last !== (i == 3)) begin
        failures++;
        $display("[TB] FAIL wrap_beat%0d: got %h resp=%0d last=%b, required %h 0 %b",
                 i, data, resp, last, exp_wrap[i], i == 3);
      end
    end
    r0_base = r0_cnt;
    ar_send(1'b0, 32'h3FC, 8'd1, 3'd2, 2'b01);
    r_get(data, resp, last);
    checks++;
    if (data !== 32'hA5A500FF || resp !== 2'b00 || last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL edge_beat0: got %h resp=%0d last=%b, required a5a500ff 0 0", data, resp, last);
    end
    r_get(data, resp, last);
    checks++;
    if (data !== 32'h0 || resp !== 2'b11 || last !== 1'b1 || r0_cnt - r0_base !== 1) begin
      failures++;
      $display("[TB] FAIL edge_beat1: got %h resp=%0d last=%b reads=%0d, required 0 3 1 1",
               data, resp, last, r0_cnt - r0_base);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp; logic id, last; logic [31:0] data;
    s_aw_id = 1'b0; s_aw_addr = 32'h20; s_aw_len = 8'd0; s_aw_size = 3'd2; s_aw_burst = 2'b01;
    s_ar_id = 1'b1; s_ar_addr = 32'h20; s_ar_len = 8'd0; s_ar_size = 3'd2; s_ar_burst = 2'b01;
    s_aw_valid = 1'b1; s_ar_valid = 1'b1;
    #1;
    checks++;
    if (s_aw_ready !== 1'b1 || s_ar_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL arb_first: got aw_ready=%b ar_ready=%b, required 1 0", s_aw_ready, s_ar_ready);
    end
    aw_wait();
    w_send(32'h88888888, 4'hF, 1'b1);
    b_get(resp, id);
    s_aw_addr = 32'h24;
    s_aw_valid = 1'b1;
    #1;
    checks++;
    if (s_aw_ready !== 1'b0 || s_ar_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL arb_second: got aw_ready=%b ar_ready=%b, required 0 1", s_aw_ready, s_ar_ready);
    end
    ar_wait();
    r_get(data, resp, last);
    checks++;
    if (data !== 32'h88888888 || resp !== 2'b00) begin
      failures++;
      $display("[TB] FAIL arb_read: got %h resp=%0d, required 88888888 0", data, resp);
    end
    aw_wait();
    w_send(32'h99999999, 4'hF, 1'b1);
    b_get(resp, id);
    checks++;
    if (resp !== 2'b00 || w0_last_addr !== 8'd9 || w0_last_data !== 32'h99999999) begin
      failures++;
      $display("[TB] FAIL arb_third: got resp=%0d addr=%0d data=%h, required 0 9 99999999",
               resp, w0_last_addr, w0_last_data);
    end
  endtask

  task automatic test_bad_size();
    logic [1:0] resp; logic id, last; logic [31:0] data; int r0_base, w0_base;
    r0_base = r0_cnt; w0_base = w0_cnt;
    aw_send(1'b0, 32'h30, 8'd0, 3'd1, 2'b01);
    w_send(32'h00001234, 4'hF, 1'b1);
    b_get(resp, id);
    checks++;
    if (resp !== 2'b10) begin
      failures++;
      $display("[TB] FAIL size_bresp: got %0d, required 2", resp);
    end
    ar_send(1'b0, 32'h10, 8'd0, 3'd1, 2'b01);
    r_get(data, resp, last);
    checks++;
    if (data !== 32'h0 || resp !== 2'b10 || last !== 1'b1) begin
      failures++;
      $display("[TB] FAIL size_rresp: got %h resp=%0d last=%b, required 0 2 1", data, resp, last);
    end
    checks++;
    if (r0_cnt != r0_base || w0_cnt != w0_base) begin
      failures++;
      $display("[TB] FAIL size_sram: got reads=%0d writes=%0d, required 0 0",
               r0_cnt - r0_base, w0_cnt - w0_base);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] resp; logic last, b_seen; logic [31:0] data; logic [6:0] outs; int w0_base;
    aw_send(1'b0, 32'h40, 8'd7, 3'd2, 2'b01);
    w_send(32'h01010101, 4'hF, 1'b0);
    s_w_data = 32'h02020202; s_w_strb = 4'hF; s_w_valid = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    outs = {s_w_ready, W0_en, R0_en, s_b_valid, s_r_valid, s_aw_ready, s_ar_ready};
    checks++;
    if (outs !== 7'b0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got %b, required all zero", outs);
    end
    w0_base = w0_cnt;
    repeat (3) @(posedge clock);
    #1;
    s_w_valid = 1'b0;
    reset_n = 1'b1;
    b_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (s_b_valid) b_seen = 1'b1;
    end
    checks++;
    if (b_seen !== 1'b0 || w0_cnt != w0_base) begin
      failures++;
      $display("[TB] FAIL midreset_quiet: got bvalid=%b writes=%0d, required 0 0",
               b_seen, w0_cnt - w0_base);
    end
    ar_send(1'b0, 32'h190, 8'd0, 3'd2, 2'b01);
    r_get(data, resp, last);
    checks++;
    if (data !== 32'hCAFEF00D || resp !== 2'b00) begin
      failures++;
      $display("[TB] FAIL midreset_read: got %h resp=%0d, required cafef00d 0", data, resp);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single_write();
    test_incr_burst();
    test_rmw();
    test_wrap_and_edge();
    test_back_to_back();
    test_bad_size();
    test_reset_mid_burst();
    checks++;
    if (hazard_cnt != 0) begin
      failures++;
      $display("[TB] FAIL port_collision: got %0d same-address R0/W0 cycles, required 0", hazard_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_sram_responder.md
Name: axi4_sram_responder

Overview:
- AXI4 (full, burst-capable) slave that terminates transactions from the wishbone-to-AXI4 bridge onto the single-port-pair SRAM macro interface (R0 read port, W0 write port, 32-bit words, no write mask).
- Partial-strobe writes are resolved by internal read-modify-write.
- Serves one transaction at a time. No outstanding transactions, no reordering.

Parameters:
- ADDR_WIDTH, 32, AXI byte-address width.
- SRAM_AW, 8, SRAM word-address width; depth = 2**SRAM_AW words.
- BASE_ADDR, 32'h0, byte base of the SRAM window; must be aligned to 4*2**SRAM_AW.
- ID_WIDTH, 1, AXI ID width.

Ports:
- clock  in  1  sole clock; also drives R0_clk/W0_clk.
- reset_n  in  1  asynchronous, active-low reset.
- s_aw_valid/s_aw_ready  in/out  1  write-address handshake.
- s_aw_id  in  ID_WIDTH
- s_aw_addr  in  ADDR_WIDTH
- s_aw_len  in  8
- s_aw_size  in  3
- s_aw_burst  in  2
- s_w_valid/s_w_ready  in/out  1
- s_w_data  in  32
- s_w_strb  in  4
- s_w_last  in  1
- s_b_valid/s_b_ready  out/in  1
- s_b_id  out  ID_WIDTH
- s_b_resp  out  2
- s_ar_valid/s_ar_ready  in/out  1
- s_ar_id  in  ID_WIDTH
- s_ar_addr  in  ADDR_WIDTH
- s_ar_len  in  8
- s_ar_size  in  3
- s_ar_burst  in  2
- s_r_valid/s_r_ready  out/in  1
- s_r_id  out  ID_WIDTH
- s_r_data  out  32
- s_r_resp  out  2
- s_r_last  out  1
- R0_clk  out  1  equals clock.
- R0_en  out  1  read enable.
- R0_addr  out  SRAM_AW  read address.
- R0_data  in  32  read data, valid the cycle after R0_en.
- W0_clk  out  1  equals clock.
- W0_en  out  1  write enable.
- W0_addr  out  SRAM_AW  write address.
- W0_data  out  32  write data.

Behaviour:
- Reset (async assert, sync deassert inside block):
  - state=IDLE.
  - All ready/valid outputs=0; R0_en=W0_en=0.
  - s_r_data=0, resp fields=0 (OKAY), s_r_last=0.
  - Arbitration pointer favours write.
- States: IDLE, RD_REQ, RD_DATA, WR_DATA, RMW_RD, RMW_WR, WR_RESP.
- IDLE:
  - s_aw_ready/s_ar_ready are combinational from state and arbitration. Only the winning channel's ready is 1.
  - If both aw and ar are valid, serve the channel not served last (round-robin); a lone request is served immediately.
  - On accept, latch id, addr, len, burst, size; beat counter=0.
- Burst validity: size!=2, burst==2'b11, or WRAP with len not in {1,3,7,15} → SLVERR for every beat, no SRAM access.
- Address sequencing:
  - FIXED keeps the address.
  - INCR adds 4 per beat; wraps modulo 2**ADDR_WIDTH.
  - WRAP wraps within an aligned (len+1)*4-byte block.
- Beat in range iff addr[ADDR_WIDTH-1:SRAM_AW+2]==BASE_ADDR[ADDR_WIDTH-1:SRAM_AW+2]; word=addr[SRAM_AW+1:2]. Out-of-range beat → DECERR, no SRAM access.
- Read path:
  - RD_REQ: R0_en=1 for one cycle (only if beat valid and in range).
  - RD_DATA: s_r_data captured from R0_data (or 0 on error); s_r_valid=1 with rresp, id, and s_r_last=(beat==len).
  - s_r_* are held stable until s_r_ready.
  - On handshake: last → IDLE, else RD_REQ.
  - Minimum 2 cycles/beat. First rvalid 2 cycles after ar handshake.
- Write path:
  - WR_DATA: s_w_ready=1.
  - On a beat with strb==4'hF: W0_en/W0_addr/W0_data registered, asserted the following cycle for exactly one cycle.
  - strb==0 or an error beat: no write.
  - Partial strb: s_w_ready drops; RMW_RD issues R0_en; RMW_WR writes the merged word (strb-selected bytes from w_data, remainder from R0_data).
  - Beat count reaching len → WR_RESP regardless of s_w_last. s_w_last mismatch (early or missing) → bresp SLVERR.
  - WR_RESP: s_b_valid=1 with the worst resp of the burst (DECERR > SLVERR > OKAY) until s_b_ready, then IDLE.
- Hazard rules:
  - R0_en and W0_en are never asserted to the same address in the same cycle.
  - A read or RMW issued after a write handshake always returns the written data.
- Reset mid-burst: abandon the transaction, no further SRAM enables, all outputs to reset values; no response is generated.
- Ready/valid outputs never depend combinationally on their own channel's valid/ready.

Test Plan:
- Single write 0xDEADBEEF, strb F, addr BASE+0x10 → W0_en one cycle, W0_addr=4, bresp=0; read back → s_r_data=0xDEADBEEF, rlast=1, rresp=0.
- INCR write len=3 at word 0 (data 1..4), then INCR read len=3 → four beats 1,2,3,4 with rlast only on 4th; s_r_ready held low 3 cycles on beat 2 → data stable.
- Word 5 = 0x11223344, write 0xAABBCCDD strb 4'b0101 → RMW sequence (R0_en then W0_en), read returns 0x11BB33DD.
- WRAP read len=3 from byte 0x18 → words 6,7,4,5; INCR read from last word len=1 → beat0 OKAY, beat1 DECERR data 0, no R0_en for beat1.
- aw and ar asserted in the same cycle twice in succession → write served first, then read, then write (round-robin); size=1 request → SLVERR, no SRAM enables.
- reset_n pulsed low during write beat 2 of len=7 → all outputs zero immediately, no b response, next read of untouched word returns prior contents.
